procyon_victim_buffer: RTL

//  Receives dirty dcache victim lines from the LSU execute stage and holds them in a FIFO.

---
 rtl/procyon_victim_buffer_if.sv | 36 +++
 rtl/procyon_victim_buffer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/procyon_victim_buffer_if.sv
// Victim buffer port bundle: victim enqueue, occupancy status, line lookup and the
// valid/ready write-back beat channel toward memory.
interface procyon_victim_buffer_if #(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_DC_LINE_SIZE = 32,
  parameter int OPTN_MEM_IF_WIDTH = 64
);
  localparam int DC_LINE_WIDTH = OPTN_DC_LINE_SIZE * 8;

  logic                         i_victim_en;
  logic [OPTN_ADDR_WIDTH-1:0]   i_victim_addr;
  logic [DC_LINE_WIDTH-1:0]     i_victim_data;
  logic                         o_full;
  logic                         o_empty;
  logic                         o_overflow;
  logic [OPTN_ADDR_WIDTH-1:0]   i_lookup_addr;
  logic                         o_lookup_hit;
  logic [DC_LINE_WIDTH-1:0]     o_lookup_data;
  logic                         o_wb_valid;
  logic                         i_wb_ready;
  logic [OPTN_ADDR_WIDTH-1:0]   o_wb_addr;
  logic [OPTN_MEM_IF_WIDTH-1:0] o_wb_data;
  logic                         o_wb_last;

  modport slave (
    input  i_victim_en, i_victim_addr, i_victim_data, i_lookup_addr, i_wb_ready,
    output o_full, o_empty, o_overflow, o_lookup_hit, o_lookup_data,
           o_wb_valid, o_wb_addr, o_wb_data, o_wb_last
  );

  modport master (
    output i_victim_en, i_victim_addr, i_victim_data, i_lookup_addr, i_wb_ready,
    input  o_full, o_empty, o_overflow, o_lookup_hit, o_lookup_data,
           o_wb_valid, o_wb_addr, o_wb_data, o_wb_last
  );
endinterface

// File: rtl/procyon_victim_buffer.sv
// Dirty-victim FIFO: buffers evicted dcache lines, drains each one to memory as a burst
// of beats, and lets fill logic see lines that have not yet reached memory.
module procyon_victim_buffer #(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_DC_LINE_SIZE = 32,
  parameter int OPTN_VQ_DEPTH     = 4,
  parameter int OPTN_MEM_IF_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  procyon_victim_buffer_if.slave vb
);
  localparam int DC_LINE_WIDTH = OPTN_DC_LINE_SIZE * 8;
  localparam int WB_BEATS      = DC_LINE_WIDTH / OPTN_MEM_IF_WIDTH;
  localparam int OFFSET_W      = $clog2(OPTN_DC_LINE_SIZE);
  localparam int PTR_W         = $clog2(OPTN_VQ_DEPTH);
  localparam int CNT_W         = PTR_W + 1;
  localparam int BEAT_W        = (WB_BEATS > 1) ? $clog2(WB_BEATS) : 1;
  localparam int BEAT_BYTES    = OPTN_MEM_IF_WIDTH / 8;

  localparam logic [BEAT_W-1:0]          LAST_BEAT = BEAT_W'(WB_BEATS - 1);
  localparam logic [CNT_W-1:0]           DEPTH_CNT = CNT_W'(OPTN_VQ_DEPTH);
  localparam logic [OPTN_ADDR_WIDTH-1:0] LINE_MASK = {OPTN_ADDR_WIDTH{1'b1}} << OFFSET_W;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                     state_q;
  logic [OPTN_ADDR_WIDTH-1:0] addr_q [OPTN_VQ_DEPTH];
  logic [DC_LINE_WIDTH-1:0]   data_q [OPTN_VQ_DEPTH];
  logic [OPTN_VQ_DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]           head_q, tail_q;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic                       overflow_q, wb_valid_q, wb_last_q;
  logic                       full, push, xfer, pop;
  logic                       lk_hit;
  logic [DC_LINE_WIDTH-1:0]   lk_data;
  logic [PTR_W-1:0]           lk_idx;

  assign full = (count_q == DEPTH_CNT);
  assign push = vb.i_victim_en & ~full;
  assign xfer = wb_valid_q & vb.i_wb_ready;
  assign pop  = xfer & wb_last_q;

  // NOTE: every variable gets a default before any conditional update so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    beat_d = beat_q;
    if (pop) begin
      beat_d = '0;
    end else if (xfer) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  // NOTE: line storage carries no reset; valid_q alone decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= vb.i_victim_addr & LINE_MASK;
      data_q[tail_q] <= vb.i_victim_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      beat_q     <= beat_d;
      overflow_q <= vb.i_victim_en & full;
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
    end
  end

  // Decisions use count_d so a line enqueued this edge is offered on the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (count_d != '0) begin
            state_q    <= SEND;
            wb_valid_q <= 1'b1;
            wb_last_q  <= (beat_d == LAST_BEAT);
          end
        end
        SEND: begin
          if (pop && (count_d == '0)) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_last_q  <= 1'b0;
          end else begin
            wb_last_q  <= (beat_d == LAST_BEAT);
          end
        end
      endcase
    end
  end

  // Scan oldest to newest so the last match, the entry nearest tail, wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = head_q;
    for (int i = 0; i < OPTN_VQ_DEPTH; i++) begin
      lk_idx = head_q + PTR_W'(i);
      if (valid_q[lk_idx] && (addr_q[lk_idx] == (vb.i_lookup_addr & LINE_MASK))) begin
        lk_hit  = 1'b1;
        lk_data = data_q[lk_idx];
      end
    end
  end

  assign vb.o_full        = full;
  assign vb.o_empty       = (count_q == '0);
  assign vb.o_overflow    = overflow_q;
  assign vb.o_lookup_hit  = lk_hit;
  assign vb.o_lookup_data = lk_data;
  assign vb.o_wb_valid    = wb_valid_q;
  assign vb.o_wb_last     = wb_last_q;
  assign vb.o_wb_addr     = addr_q[head_q]
                          + OPTN_ADDR_WIDTH'(beat_q) * OPTN_ADDR_WIDTH'(BEAT_BYTES);
  assign vb.o_wb_data     = data_q[head_q][int'(beat_q) * OPTN_MEM_IF_WIDTH +: OPTN_MEM_IF_WIDTH];
endmodule
